multi_alarm_unit: RTL and testbench
===================================

// Module: multi_alarm_unit
// PURPOSE
//  Parametrised multi-channel alarm controller; successor to the single-alarm unit.
//  Holds NUM_ALARMS programmable BCD hr:min alarms, compares them against the running
//  BCD time from the timekeeper, arbitrates simultaneous hits and drives one alert.
//  Adds ring timeout, pending queue and optional snooze. Sits after the timekeeper memory.
// PARAMETERS
//  NUM_ALARMS   4   number of alarm channels (2..16)
//  IDX_W        2   channel index width, = clog2(NUM_ALARMS)
//  RING_SECS    60  seconds alert stays up before auto-dismiss (1..255)
//  SNOOZE_MINS  5   snooze length in minutes (1..59)
// PORTS
//  system_clk  in   1           system clock, rising edge
//  reset       in   1           async, active-low; all state cleared while 0
//  sec_tick    in   1           1-cycle pulse per second, sync to system_clk
//  cur_sec     in   8           current seconds, BCD 00-59
//  cur_min     in   8           current minutes, BCD 00-59
//  cur_hr      in   8           current hours, BCD 00-23
//  wr_en       in   1           write alarm channel wr_idx this cycle
//  wr_idx      in   IDX_W       channel to write
//  wr_min      in   8           alarm minute, BCD
//  wr_hr       in   8           alarm hour, BCD
//  wr_arm      in   1           arm (1) / disarm (0) the written channel
//  dismiss     in   1           stop current alert (level, sampled each cycle)
//  snooze      in   1           snooze current alert (ignored without macro)
//  alert       out  1           registered; 1 while state==RING
//  active_idx  out  IDX_W       channel ringing/snoozed; holds last value in IDLE
//  pending     out  NUM_ALARMS  registered mask of triggered, not-yet-served channels
//  armed       out  NUM_ALARMS  registered arm bits
// BEHAVIOUR
//  Reset: alarm regs 00:00, armed=0, pending=0, alert=0, active_idx=0, state IDLE.
//  Write: on wr_en, channel wr_idx min/hr/arm updated next edge. Invalid BCD stored as-is.
//   Disarming the active channel -> state IDLE, alert=0 next edge; disarm clears its pending bit.
//  Match: cycle with sec_tick=1, cur_sec==8'h00, armed[i], hr/min equal -> pending[i]=1 next edge.
//   Match uses pre-write values if wr_en hits same channel same cycle.
//   Match on channel already active (RING/SNOOZE) is ignored; already-pending bit stays 1.
//  FSM IDLE/RING/SNOOZE:
//   IDLE: pending!=0 -> RING; active_idx=lowest set index; that pending bit cleared; ring_cnt=0.
//    Latency: alert rises on 2nd rising edge after the matching sec_tick cycle.
//   RING: dismiss -> IDLE (alert 0 next edge). dismiss wins over snooze same cycle.
//    snooze (macro on) -> SNOOZE, snz_cnt=SNOOZE_MINS*60.
//    sec_tick with ring_cnt==RING_SECS-1 -> IDLE (auto-dismiss); else sec_tick increments ring_cnt.
//   SNOOZE: sec_tick decrements snz_cnt; at 1->0 transition -> RING, ring_cnt=0, same active_idx.
//    dismiss -> IDLE.
//  Pending hits on other channels accumulate during RING/SNOOZE; served lowest-first from IDLE,
//   one IDLE cycle between consecutive alerts.
//  Counters: ring_cnt 8 bit; snz_cnt clog2(SNOOZE_MINS*60+1) bits; no wrap, saturating guards.
// CONFIGURATION
//  MULTI_ALARM_SNOOZE_EN defined: SNOOZE state and snz_cnt present, behaviour as above.
//  Undefined: snooze port ignored, no SNOOZE state/counter; RING exits only by dismiss,
//   timeout or disarm.
// TESTING
//  T1 reset low mid-RING -> alert=0, pending=0, armed=0 immediately (async).
//  T2 ch1=07:30 armed; time 07:29:59 -> tick to 07:30:00 -> alert=1 two edges later, active_idx=1.
//  T3 ch0,ch2 both 06:00 -> alert ch0, pending=4'b0100; dismiss -> 1 IDLE cycle, ch2 rings.
//  T4 RING_SECS=60, no dismiss -> alert drops on 60th sec_tick after rise; pending unchanged.
//  T5 (SNOOZE_EN) snooze at 08:00:05 -> alert 0; re-rings 300 sec_ticks later, same idx;
//     dismiss+snooze same cycle -> IDLE.
//  T6 disarm ringing ch3 via wr_en/wr_arm=0 -> alert 0 next edge; write ch with AA:AA never fires.

Source files
------------

// File: rtl/multi_alarm_unit.sv
// Multi-channel BCD hr:min alarm controller with arbitration, ring timeout and pending queue.
// Optional snooze support is enabled by defining MULTI_ALARM_SNOOZE_EN.
module multi_alarm_unit #(
    parameter int NUM_ALARMS  = 4,
    parameter int IDX_W       = 2,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_MINS = 5
) (
    input  logic                  system_clk,
    input  logic                  reset,
    input  logic                  sec_tick,
    input  logic [7:0]            cur_sec,
    input  logic [7:0]            cur_min,
    input  logic [7:0]            cur_hr,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [7:0]            wr_min,
    input  logic [7:0]            wr_hr,
    input  logic                  wr_arm,
    input  logic                  dismiss,
    input  logic                  snooze,
    output logic                  alert,
    output logic [IDX_W-1:0]      active_idx,
    output logic [NUM_ALARMS-1:0] pending,
    output logic [NUM_ALARMS-1:0] armed
);

`ifdef MULTI_ALARM_SNOOZE_EN
    localparam int SNZ_LOAD = SNOOZE_MINS * 60;
    localparam int SNZ_W    = $clog2(SNZ_LOAD + 1);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    logic [SNZ_W-1:0] snz_cnt, snz_cnt_nxt;
`else
    typedef enum logic [1:0] {IDLE, RING} state_t;

    logic snooze_unused;
    assign snooze_unused = snooze;
`endif

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx_nxt;
    logic [IDX_W-1:0]        serve_idx;
    logic [7:0]              ring_cnt, ring_cnt_nxt;
    logic [NUM_ALARMS-1:0]   pending_nxt;
    logic [NUM_ALARMS-1:0]   hit;
    logic [7:0]              alarm_min [NUM_ALARMS];
    logic [7:0]              alarm_hr  [NUM_ALARMS];
    logic                    busy;
    logic                    disarm_wr;
    logic                    disarm_active;

    assign busy          = (state != IDLE);
    assign disarm_wr     = wr_en && !wr_arm;
    assign disarm_active = disarm_wr && (wr_idx == active_idx) && busy;

    // Compares against registered alarm values, so a same-cycle write is seen only afterwards
    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            hit[i] = sec_tick && (cur_sec == 8'h00) && armed[i] &&
                     (alarm_hr[i] == cur_hr) && (alarm_min[i] == cur_min) &&
                     !(busy && (active_idx == IDX_W'(i)));
        end
    end

    always_comb begin
        serve_idx = '0;
        for (int unsigned i = NUM_ALARMS; i > 0; i--) begin
            if (pending[i-1]) serve_idx = IDX_W'(i - 1);
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = active_idx;
        ring_cnt_nxt = ring_cnt;
        pending_nxt  = pending | hit;
`ifdef MULTI_ALARM_SNOOZE_EN
        snz_cnt_nxt  = snz_cnt;
`endif
        case (state)
            IDLE: begin
                if (|pending) begin
                    state_nxt    = RING;
                    idx_nxt      = serve_idx;
                    ring_cnt_nxt = '0;
                    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
                        if (serve_idx == IDX_W'(i)) pending_nxt[i] = 1'b0;
                    end
                end
            end
            RING: begin
                if (dismiss) begin
                    state_nxt = IDLE;
`ifdef MULTI_ALARM_SNOOZE_EN
                end else if (snooze) begin
                    state_nxt   = SNOOZE;
                    snz_cnt_nxt = SNZ_W'(SNZ_LOAD);
`endif
                end else if (sec_tick) begin
                    if (ring_cnt >= 8'(RING_SECS - 1)) state_nxt = IDLE;
                    else ring_cnt_nxt = ring_cnt + 8'd1;
                end
            end
`ifdef MULTI_ALARM_SNOOZE_EN
            SNOOZE: begin
                if (dismiss) begin
                    state_nxt = IDLE;
                end else if (sec_tick) begin
                    if (snz_cnt <= SNZ_W'(1)) begin
                        state_nxt    = RING;
                        ring_cnt_nxt = '0;
                        snz_cnt_nxt  = '0;
                    end else begin
                        snz_cnt_nxt = snz_cnt - SNZ_W'(1);
                    end
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase

        if (disarm_active) state_nxt = IDLE;

        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            if (disarm_wr && (wr_idx == IDX_W'(i))) pending_nxt[i] = 1'b0;
        end
    end

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            active_idx <= '0;
            ring_cnt   <= '0;
            pending    <= '0;
            alert      <= 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
            snz_cnt    <= '0;
`endif
        end else begin
            state      <= state_nxt;
            active_idx <= idx_nxt;
            ring_cnt   <= ring_cnt_nxt;
            pending    <= pending_nxt;
            alert      <= (state_nxt == RING);
`ifdef MULTI_ALARM_SNOOZE_EN
            snz_cnt    <= snz_cnt_nxt;
`endif
        end
    end

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            armed <= '0;
            for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
                alarm_min[i] <= '0;
                alarm_hr[i]  <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    alarm_min[i] <= wr_min;
                    alarm_hr[i]  <= wr_hr;
                    armed[i]     <= wr_arm;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_alarm_unit.sv
// Self-checking bench for multi_alarm_unit: directed scenarios plus randomized traffic
// compared against a behavioural model of the alarm rules.
module tb_multi_alarm_unit;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int RS = 60;
    localparam int SM = 5;
`ifdef MULTI_ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    logic          system_clk = 1'b0;
    logic          reset;
    logic          sec_tick;
    logic [7:0]    cur_sec, cur_min, cur_hr;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [7:0]    wr_min, wr_hr;
    logic          wr_arm;
    logic          dismiss, snooze;
    logic          alert;
    logic [IW-1:0] active_idx;
    logic [N-1:0]  pending, armed;

    int checks = 0;
    int fails  = 0;

    // Behavioural model: mode 0 = quiet, 1 = ringing, 2 = snoozed
    bit         m_armed [N];
    logic [7:0] m_hr    [N];
    logic [7:0] m_min   [N];
    bit         m_pend  [N];
    int         m_mode, m_idx, m_ring_left, m_snz_left;

    multi_alarm_unit #(.NUM_ALARMS(N), .IDX_W(IW), .RING_SECS(RS), .SNOOZE_MINS(SM)) dut (
        .system_clk(system_clk), .reset(reset), .sec_tick(sec_tick),
        .cur_sec(cur_sec), .cur_min(cur_min), .cur_hr(cur_hr),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_min(wr_min), .wr_hr(wr_hr), .wr_arm(wr_arm),
        .dismiss(dismiss), .snooze(snooze),
        .alert(alert), .active_idx(active_idx), .pending(pending), .armed(armed)
    );

    always #5 system_clk = ~system_clk;

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [N-1:0] m_pend_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [N-1:0] m_armed_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_armed[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_armed[i] = 1'b0; m_hr[i] = 8'h00; m_min[i] = 8'h00; m_pend[i] = 1'b0;
        end
        m_mode = 0; m_idx = 0; m_ring_left = 0; m_snz_left = 0;
    endtask

    task automatic model_edge();
        bit nxt [N];
        int old_mode;
        int first;
        old_mode = m_mode;
        first    = -1;
        for (int i = 0; i < N; i++) begin
            nxt[i] = m_pend[i] | (sec_tick && cur_sec == 8'h00 && m_armed[i] &&
                     m_hr[i] == cur_hr && m_min[i] == cur_min && !(m_mode != 0 && m_idx == i));
        end
        if (m_mode == 0) begin
            for (int i = N - 1; i >= 0; i--) if (m_pend[i]) first = i;
            if (first >= 0) begin
                m_mode = 1; m_idx = first; m_ring_left = RS; nxt[first] = 1'b0;
            end
        end else if (m_mode == 1) begin
            if (dismiss) m_mode = 0;
            else if (snooze && SNZ_EN) begin
                m_mode = 2; m_snz_left = SM * 60;
            end else if (sec_tick) begin
                m_ring_left--;
                if (m_ring_left == 0) m_mode = 0;
            end
        end else begin
            if (dismiss) m_mode = 0;
            else if (sec_tick) begin
                m_snz_left--;
                if (m_snz_left == 0) begin
                    m_mode = 1; m_ring_left = RS;
                end
            end
        end
        if (wr_en && !wr_arm) begin
            nxt[wr_idx] = 1'b0;
            if (old_mode != 0 && int'(wr_idx) == m_idx) m_mode = 0;
        end
        if (wr_en) begin
            m_hr[wr_idx] = wr_hr; m_min[wr_idx] = wr_min; m_armed[wr_idx] = wr_arm;
        end
        for (int i = 0; i < N; i++) m_pend[i] = nxt[i];
    endtask

    task automatic step();
        @(posedge system_clk);
        if (reset) model_edge();
        #1;
        sec_tick = 1'b0; wr_en = 1'b0; dismiss = 1'b0; snooze = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_hr = bcd(h); cur_min = bcd(m); cur_sec = bcd(s);
    endtask

    task automatic tick_at(input int h, input int m, input int s);
        set_time(h, m, s);
        sec_tick = 1'b1;
        step();
    endtask

    task automatic write_ch(input int idx, input logic [7:0] h, input logic [7:0] m, input bit arm);
        wr_en = 1'b1; wr_idx = IW'(idx); wr_hr = h; wr_min = m; wr_arm = arm;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        #12;
        checks++; if (alert !== 1'b0) begin fails++; $display("FAIL rst_alert: got %b exp 0", alert); end
        checks++; if (active_idx !== 2'd0) begin fails++; $display("FAIL rst_idx: got %0d exp 0", active_idx); end
        checks++; if (pending !== 4'b0000) begin fails++; $display("FAIL rst_pending: got %b exp 0000", pending); end
        checks++; if (armed !== 4'b0000) begin fails++; $display("FAIL rst_armed: got %b exp 0000", armed); end
        reset = 1'b1;
    endtask

    task automatic test_single();
        write_ch(1, 8'h07, 8'h30, 1'b1);
        checks++; if (armed !== 4'b0010) begin fails++; $display("FAIL t2_armed: got %b exp 0010", armed); end
        tick_at(7, 29, 59);
        checks++; if (pending !== 4'b0000 || alert !== 1'b0) begin fails++; $display("FAIL t2_premature: pending %b alert %b exp 0000/0", pending, alert); end
        tick_at(7, 30, 0);
        checks++; if (pending !== 4'b0010) begin fails++; $display("FAIL t2_pending: got %b exp 0010", pending); end
        checks++; if (alert !== 1'b0) begin fails++; $display("FAIL t2_alert_edge1: got %b exp 0", alert); end
        step();
        checks++; if (alert !== 1'b1) begin fails++; $display("FAIL t2_alert_edge2: got %b exp 1", alert); end
        checks++; if (active_idx !== 2'd1) begin fails++; $display("FAIL t2_idx: got %0d exp 1", active_idx); end
        checks++; if (pending !== 4'b0000) begin fails++; $display("FAIL t2_served: got %b exp 0000", pending); end
        dismiss = 1'b1; step();
        checks++; if (alert !== 1'b0) begin fails++; $display("FAIL t2_dismiss: got %b exp 0", alert); end
    endtask

    task automatic test_simultaneous();
        write_ch(0, 8'h06, 8'h00, 1'b1);
        write_ch(2, 8'h06, 8'h00, 1'b1);
        tick_at(6, 0, 0);
        checks++; if (pending !== 4'b0101) begin fails++; $display("FAIL t3_pending: got %b exp 0101", pending); end
        step();
        checks++; if (alert !== 1'b1 || active_idx !== 2'd0) begin fails++; $display("FAIL t3_first: alert %b idx %0d exp 1/0", alert, active_idx); end
        checks++; if (pending !== 4'b0100) begin fails++; $display("FAIL t3_queue: got %b exp 0100", pending); end
        dismiss = 1'b1; step();
        checks++; if (alert !== 1'b0 || pending !== 4'b0100) begin fails++; $display("FAIL t3_gap: alert %b pending %b exp 0/0100", alert, pending); end
        step();
        checks++; if (alert !== 1'b1 || active_idx !== 2'd2) begin fails++; $display("FAIL t3_second: alert %b idx %0d exp 1/2", alert, active_idx); end
        checks++; if (pending !== 4'b0000) begin fails++; $display("FAIL t3_drained: got %b exp 0000", pending); end
        dismiss = 1'b1; step();
    endtask

    task automatic test_timeout();
        write_ch(3, 8'h09, 8'h15, 1'b1);
        tick_at(9, 15, 0);
        step();
        checks++; if (alert !== 1'b1 || active_idx !== 2'd3) begin fails++; $display("FAIL t4_ring: alert %b idx %0d exp 1/3", alert, active_idx); end
        for (int k = 1; k <= RS; k++) begin
            if (k == 10) tick_at(7, 30, 0);
            else tick_at(9, 15, 1);
            if (k == RS - 1) begin
                checks++; if (alert !== 1'b1 || pending !== 4'b0010) begin fails++; $display("FAIL t4_before: alert %b pending %b exp 1/0010", alert, pending); end
            end
        end
        checks++; if (alert !== 1'b0 || pending !== 4'b0010) begin fails++; $display("FAIL t4_timeout: alert %b pending %b exp 0/0010", alert, pending); end
        checks++; if (active_idx !== 2'd3) begin fails++; $display("FAIL t4_idx_hold: got %0d exp 3", active_idx); end
        step();
        checks++; if (alert !== 1'b1 || active_idx !== 2'd1) begin fails++; $display("FAIL t4_queued: alert %b idx %0d exp 1/1", alert, active_idx); end
        dismiss = 1'b1; step();
    endtask

    task automatic test_snooze();
        write_ch(0, 8'h08, 8'h00, 1'b1);
        tick_at(8, 0, 0);
        step();
        checks++; if (alert !== 1'b1 || active_idx !== 2'd0) begin fails++; $display("FAIL t5_ring: alert %b idx %0d exp 1/0", alert, active_idx); end
        for (int s = 1; s <= 4; s++) tick_at(8, 0, s);
        set_time(8, 0, 5);
        snooze = 1'b1; step();
`ifdef MULTI_ALARM_SNOOZE_EN
        checks++; if (alert !== 1'b0) begin fails++; $display("FAIL t5_snoozed: got %b exp 0", alert); end
        for (int k = 1; k <= SM * 60; k++) begin
            tick_at(8, 1, 1);
            if (k == SM * 60 - 1) begin
                checks++; if (alert !== 1'b0) begin fails++; $display("FAIL t5_early: got %b exp 0", alert); end
            end
        end
        checks++; if (alert !== 1'b1 || active_idx !== 2'd0) begin fails++; $display("FAIL t5_rering: alert %b idx %0d exp 1/0", alert, active_idx); end
        dismiss = 1'b1; snooze = 1'b1; step();
        checks++; if (alert !== 1'b0) begin fails++; $display("FAIL t5_dismiss_wins: got %b exp 0", alert); end
        for (int k = 0; k <= SM * 60; k++) tick_at(8, 1, 1);
        checks++; if (alert !== 1'b0) begin fails++; $display("FAIL t5_no_resnooze: got %b exp 0", alert); end
`else
        checks++; if (alert !== 1'b1) begin fails++; $display("FAIL t5_snooze_ignored: got %b exp 1", alert); end
        dismiss = 1'b1; step();
        checks++; if (alert !== 1'b0) begin fails++; $display("FAIL t5_dismiss: got %b exp 0", alert); end
`endif
    endtask

    task automatic test_disarm();
        tick_at(9, 15, 0);
        step();
        checks++; if (alert !== 1'b1 || active_idx !== 2'd3) begin fails++; $display("FAIL t6_ring: alert %b idx %0d exp 1/3", alert, active_idx); end
        write_ch(3, 8'h09, 8'h15, 1'b0);
        checks++; if (alert !== 1'b0) begin fails++; $display("FAIL t6_disarm_alert: got %b exp 0", alert); end
        checks++; if (armed !== 4'b0111) begin fails++; $display("FAIL t6_armed: got %b exp 0111", armed); end
        write_ch(1, 8'hAA, 8'hAA, 1'b1);
        tick_at(10, 10, 0);
        tick_at(23, 59, 0);
        tick_at(0, 0, 0);
        step();
        checks++; if (pending !== 4'b0000 || alert !== 1'b0) begin fails++; $display("FAIL t6_invalid_bcd: pending %b alert %b exp 0000/0", pending, alert); end
    endtask

    task automatic test_async_reset();
        tick_at(6, 0, 0);
        step();
        checks++; if (alert !== 1'b1 || active_idx !== 2'd2) begin fails++; $display("FAIL t1_ring: alert %b idx %0d exp 1/2", alert, active_idx); end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (alert !== 1'b0) begin fails++; $display("FAIL t1_alert: got %b exp 0", alert); end
        checks++; if (pending !== 4'b0000 || armed !== 4'b0000) begin fails++; $display("FAIL t1_state: pending %b armed %b exp 0000/0000", pending, armed); end
        checks++; if (active_idx !== 2'd0) begin fails++; $display("FAIL t1_idx: got %0d exp 0", active_idx); end
        @(negedge system_clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_random();
        logic [7:0] hr_pick [3];
        hr_pick[0] = 8'h06; hr_pick[1] = 8'h07; hr_pick[2] = 8'hAA;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                wr_en  = 1'b1;
                wr_idx = IW'($urandom_range(0, N - 1));
                wr_hr  = hr_pick[$urandom_range(0, 2)];
                wr_min = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'h01;
                wr_arm = ($urandom_range(0, 3) != 0);
            end
            cur_hr   = ($urandom_range(0, 1) != 0) ? 8'h06 : 8'h07;
            cur_min  = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'h01;
            cur_sec  = ($urandom_range(0, 1) != 0) ? 8'h00 : bcd($urandom_range(1, 59));
            sec_tick = ($urandom_range(0, 1) != 0);
            dismiss  = ($urandom_range(0, 39) == 0);
            snooze   = ($urandom_range(0, 29) == 0);
            step();
            checks++; if (alert !== (m_mode == 1)) begin fails++; $display("FAIL rnd_alert c=%0d: got %b exp %b", c, alert, (m_mode == 1)); end
            checks++; if (active_idx !== IW'(m_idx)) begin fails++; $display("FAIL rnd_idx c=%0d: got %0d exp %0d", c, active_idx, m_idx); end
            checks++; if (pending !== m_pend_vec()) begin fails++; $display("FAIL rnd_pending c=%0d: got %b exp %b", c, pending, m_pend_vec()); end
            checks++; if (armed !== m_armed_vec()) begin fails++; $display("FAIL rnd_armed c=%0d: got %b exp %b", c, armed, m_armed_vec()); end
        end
    endtask

    initial begin
        sec_tick = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_min = 8'h00; wr_hr = 8'h00;
        wr_arm = 1'b0; dismiss = 1'b0; snooze = 1'b0;
        cur_hr = 8'h00; cur_min = 8'h00; cur_sec = 8'h01;
        test_reset();
        test_single();
        test_simultaneous();
        test_timeout();
        test_snooze();
        test_disarm();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
